// File: rtl/medidor_periodo_onda.sv
// Purpose: measures period and high time of an external square wave in prescaled ticks.
// Latency: results appear ETAPAS_SYNC+2 cycles after the closing input rising edge.
// Backpressure: none; dato_valido is a one-cycle strobe that the reader cannot stall.
//
// Ports:
//   reloj_placa   board clock, all logic on its rising edge
//   reset         synchronous active-high reset
//   onda_cuad     asynchronous square-wave input
//   habilitar     measurement enable; low parks the meter in ESPERA
//   valor_periodo last completed period, ticks (saturates at 2^ANCHO-1)
//   valor_alto    high time of that same period, ticks
//   dato_valido   one-cycle strobe: measurement outputs updated this cycle
//   desborde      last period (or its high time) saturated
//   sin_senal     no rising edge seen for TIMEOUT_TICKS ticks
module medidor_periodo_onda #(
    parameter int CICLOS_POR_TICK = 50,
    parameter int ANCHO           = 12,
    parameter int ETAPAS_SYNC     = 2,
    parameter int TIMEOUT_TICKS   = 8192
) (
    input  logic             reloj_placa,
    input  logic             reset,
    input  logic             onda_cuad,
    input  logic             habilitar,
    output logic [ANCHO-1:0] valor_periodo,
    output logic [ANCHO-1:0] valor_alto,
    output logic             dato_valido,
    output logic             desborde,
    output logic             sin_senal
);

    localparam int ANCHO_PRES = $clog2(CICLOS_POR_TICK);
    localparam int ANCHO_SIL  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [ANCHO-1:0]      MAX       = '1;
    localparam logic [ANCHO-1:0]      UNO_CNT   = ANCHO'(1);
    localparam logic [ANCHO_PRES-1:0] PRES_ULT  = ANCHO_PRES'(CICLOS_POR_TICK - 1);
    localparam logic [ANCHO_PRES-1:0] PRES_UNO  = ANCHO_PRES'(1);
    localparam logic [ANCHO_SIL-1:0]  SIL_LIM   = ANCHO_SIL'(TIMEOUT_TICKS);
    localparam logic [ANCHO_SIL-1:0]  SIL_PEN   = ANCHO_SIL'(TIMEOUT_TICKS - 1);
    localparam logic [ANCHO_SIL-1:0]  UNO_SIL   = ANCHO_SIL'(1);

    typedef enum logic {
        ESPERA,
        MIDIENDO
    } estado_t;

    estado_t                estado;
    logic [ETAPAS_SYNC-1:0] sync_reg;
    logic                   onda_prev;
    logic [ANCHO_PRES-1:0]  cnt_pres;
    logic [ANCHO-1:0]       cnt_periodo;
    logic [ANCHO-1:0]       cnt_alto;
    logic                   saturado;
    logic [ANCHO_SIL-1:0]   cnt_sil;

    logic onda_sinc;
    logic subida;
    logic bajada;
    logic tick;
    logic fin_silencio;

    assign onda_sinc = sync_reg[ETAPAS_SYNC-1];
    assign subida    = onda_sinc & ~onda_prev;
    assign bajada    = ~onda_sinc & onda_prev;
    // An edge restarts the time base, so a tick landing on the edge cycle is dropped.
    assign tick         = (cnt_pres == PRES_ULT) && !subida;
    assign fin_silencio = tick && (cnt_sil == SIL_PEN);

    always_ff @(posedge reloj_placa) begin
        if (reset) begin
            estado        <= ESPERA;
            sync_reg      <= '0;
            onda_prev     <= 1'b0;
            cnt_pres      <= '0;
            cnt_periodo   <= '0;
            cnt_alto      <= '0;
            saturado      <= 1'b0;
            cnt_sil       <= '0;
            valor_periodo <= '0;
            valor_alto    <= '0;
            dato_valido   <= 1'b0;
            desborde      <= 1'b0;
            sin_senal     <= 1'b0;
        end else begin
            // The synchroniser keeps running while disabled so that re-enabling
            // never sees a stale level as a fresh edge.
            sync_reg    <= {sync_reg[ETAPAS_SYNC-2:0], onda_cuad};
            onda_prev   <= onda_sinc;
            dato_valido <= 1'b0;

            if (!habilitar) begin
                estado      <= ESPERA;
                cnt_pres    <= '0;
                cnt_periodo <= '0;
                cnt_alto    <= '0;
                saturado    <= 1'b0;
                cnt_sil     <= '0;
            end else begin
                // Prescaler: edge cycle is cycle 0, so the next cycle holds 1 and
                // the tick lands on cycle CICLOS_POR_TICK-1 after the edge.
                if (subida) begin
                    cnt_pres <= PRES_UNO;
                end else if (tick) begin
                    cnt_pres <= '0;
                end else begin
                    cnt_pres <= cnt_pres + PRES_UNO;
                end

                // Silence counter runs in both states and parks at its limit.
                if (subida) begin
                    cnt_sil   <= '0;
                    sin_senal <= 1'b0;
                end else if (tick && (cnt_sil != SIL_LIM)) begin
                    cnt_sil <= cnt_sil + UNO_SIL;
                    if (fin_silencio) begin
                        sin_senal <= 1'b1;
                    end
                end

                case (estado)
                    ESPERA: begin
                        cnt_periodo <= '0;
                        cnt_alto    <= '0;
                        saturado    <= 1'b0;
                        if (subida) begin
                            estado <= MIDIENDO;
                        end
                    end
                    MIDIENDO: begin
                        if (subida) begin
                            valor_periodo <= cnt_periodo;
                            valor_alto    <= cnt_alto;
                            desborde      <= saturado;
                            dato_valido   <= 1'b1;
                            cnt_periodo   <= '0;
                            cnt_alto      <= '0;
                            saturado      <= 1'b0;
                        end else if (fin_silencio) begin
                            estado      <= ESPERA;
                            cnt_periodo <= '0;
                            cnt_alto    <= '0;
                            saturado    <= 1'b0;
                        end else begin
                            if (tick) begin
                                // Flag only when a tick is lost, i.e. the true count exceeds MAX.
                                if (cnt_periodo == MAX) begin
                                    saturado <= 1'b1;
                                end else begin
                                    cnt_periodo <= cnt_periodo + UNO_CNT;
                                end
                            end
                            // Captures ticks strictly before the falling edge; it is
                            // already saturated because cnt_periodo is.
                            if (bajada) begin
                                cnt_alto <= cnt_periodo;
                            end
                        end
                    end
                    default: estado <= ESPERA;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_medidor_periodo_onda.sv
// Bench for medidor_periodo_onda with CICLOS_POR_TICK=4, ANCHO=8, TIMEOUT_TICKS=300.
// A table of square-wave segments is played back-to-back and every strobe is compared
// in order; hand-written sequences cover timeout, enable drop and mid-period reset.
module tb_medidor_periodo_onda;

    localparam int C  = 4;
    localparam int AN = 8;
    localparam int ES = 2;
    localparam int TO = 300;

    logic          reloj_placa = 1'b0;
    logic          reset;
    logic          onda_cuad;
    logic          habilitar;
    logic [AN-1:0] valor_periodo;
    logic [AN-1:0] valor_alto;
    logic          dato_valido;
    logic          desborde;
    logic          sin_senal;

    medidor_periodo_onda #(
        .CICLOS_POR_TICK(C),
        .ANCHO          (AN),
        .ETAPAS_SYNC    (ES),
        .TIMEOUT_TICKS  (TO)
    ) dut (
        .reloj_placa  (reloj_placa),
        .reset        (reset),
        .onda_cuad    (onda_cuad),
        .habilitar    (habilitar),
        .valor_periodo(valor_periodo),
        .valor_alto   (valor_alto),
        .dato_valido  (dato_valido),
        .desborde     (desborde),
        .sin_senal    (sin_senal)
    );

    always #5 reloj_placa = ~reloj_placa;

    typedef struct {
        int per;
        int alto;
        int reps;
        int exp_per;
        int exp_alto;
        int exp_des;
    } vec_t;

    typedef struct {
        int per;
        int alto;
        int des;
    } strobe_t;

    strobe_t cola[$];
    int      dobles  = 0;
    logic    dv_prev = 1'b0;
    int      checks  = 0;
    int      errors  = 0;

    // Record every strobe; a strobe high on two consecutive cycles counts as a double.
    always @(negedge reloj_placa) begin
        strobe_t s;
        if (dato_valido === 1'b1) begin
            s.per  = int'(valor_periodo);
            s.alto = int'(valor_alto);
            s.des  = int'(desborde);
            cola.push_back(s);
            if (dv_prev) dobles++;
        end
        dv_prev = (dato_valido === 1'b1);
    end

    task automatic chk(input string nombre, input int actual, input int esperado);
        checks++;
        if (actual != esperado) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d", nombre, actual, esperado);
        end
    endtask

    // Drives reps periods of per cycles, high for the first alto cycles of each.
    // habilitar is low for k in [ds, ds+dl), reset is high for k in [rs, rs+rl).
    task automatic ondas(input int per, input int alto, input int reps,
                         input int ds, input int dl, input int rs, input int rl);
        int k;
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < per; c++) begin
                k = r * per + c;
                @(negedge reloj_placa);
                onda_cuad = (c < alto);
                habilitar = !(k >= ds && k < ds + dl);
                reset     = (k >= rs && k < rs + rl);
            end
        end
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge reloj_placa);
    endtask

    initial begin
        vec_t    tabla[8];
        strobe_t esperado[$];
        strobe_t e;
        int      n0;

        tabla[0] = '{40,   10,   4, 10,  2,   0};
        tabla[1] = '{43,   21,   3, 10,  5,   0};
        tabla[2] = '{8,    4,    3, 2,   1,   0};
        tabla[3] = '{1100, 550,  2, 255, 137, 1};
        tabla[4] = '{40,   10,   2, 10,  2,   0};
        tabla[5] = '{12,   6,    2, 3,   1,   0};
        tabla[6] = '{1150, 1100, 1, 255, 255, 1};
        tabla[7] = '{7,    3,    2, 1,   0,   0};

        reset     = 1'b1;
        onda_cuad = 1'b0;
        habilitar = 1'b1;
        espera(4);
        chk("rst_periodo",  int'(valor_periodo), 0);
        chk("rst_alto",     int'(valor_alto),    0);
        chk("rst_valido",   int'(dato_valido),   0);
        chk("rst_desborde", int'(desborde),      0);
        chk("rst_sin_senal", int'(sin_senal),    0);
        reset = 1'b0;

        // Table: the first edge only starts measuring; every later edge closes one period.
        for (int i = 0; i < 8; i++) begin
            ondas(tabla[i].per, tabla[i].alto, tabla[i].reps, -1, 0, -1, 0);
            for (int r = 0; r < tabla[i].reps; r++) begin
                e.per  = tabla[i].exp_per;
                e.alto = tabla[i].exp_alto;
                e.des  = tabla[i].exp_des;
                esperado.push_back(e);
            end
        end
        // Closing edge for the last table segment, then the line goes quiet.
        ondas(40, 10, 1, -1, 0, -1, 0);

        chk("tabla_num_strobes", cola.size(), esperado.size());
        for (int i = 0; i < esperado.size(); i++) begin
            if (i < cola.size()) begin
                chk($sformatf("tabla_periodo[%0d]", i),  cola[i].per,  esperado[i].per);
                chk($sformatf("tabla_alto[%0d]", i),     cola[i].alto, esperado[i].alto);
                chk($sformatf("tabla_desborde[%0d]", i), cola[i].des,  esperado[i].des);
            end else begin
                chk($sformatf("tabla_strobe_falta[%0d]", i), 0, 1);
            end
        end

        // Loss of signal: 300 ticks after the last detected edge.
        n0 = cola.size();
        espera(1100);
        chk("sil_antes_timeout", int'(sin_senal), 0);
        espera(100);
        chk("sil_timeout", int'(sin_senal), 1);
        chk("sil_ret_periodo", int'(valor_periodo), 1);
        chk("sil_ret_alto",    int'(valor_alto),    0);
        chk("sil_ret_desborde", int'(desborde),     0);
        chk("sil_sin_strobes", cola.size(), n0);

        // Restart: first edge clears sin_senal without a strobe, second edge strobes.
        ondas(40, 10, 1, -1, 0, -1, 0);
        chk("reinicio_sin_senal", int'(sin_senal), 0);
        chk("reinicio_sin_strobe", cola.size(), n0);
        ondas(40, 10, 1, -1, 0, -1, 0);
        chk("reinicio_strobe", cola.size(), n0 + 1);
        chk("reinicio_periodo", int'(valor_periodo), 10);
        chk("reinicio_alto",    int'(valor_alto),    2);

        // Enable dropped for 100 cycles mid-period.
        n0 = cola.size();
        ondas(40, 10, 5, 30, 100, -1, 0);
        chk("hab_strobes_durante", cola.size(), n0 + 1);
        ondas(40, 10, 1, -1, 0, -1, 0);
        chk("hab_strobes_despues", cola.size(), n0 + 2);
        chk("hab_periodo",  int'(valor_periodo), 10);
        chk("hab_alto",     int'(valor_alto),    2);
        chk("hab_desborde", int'(desborde),      0);

        // Reset mid-period, spanning a rising edge that must be ignored.
        n0 = cola.size();
        ondas(40, 10, 3, -1, 0, 38, 18);
        chk("rst2_periodo",  int'(valor_periodo), 0);
        chk("rst2_alto",     int'(valor_alto),    0);
        chk("rst2_desborde", int'(desborde),      0);
        chk("rst2_sin_senal", int'(sin_senal),    0);
        chk("rst2_strobes",  cola.size(), n0 + 1);
        ondas(40, 10, 1, -1, 0, -1, 0);
        chk("rst2_strobe_final", cola.size(), n0 + 2);
        chk("rst2_periodo_final", int'(valor_periodo), 10);
        chk("rst2_alto_final",    int'(valor_alto),    2);

        chk("strobe_un_ciclo", dobles, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
